// File: rtl/array_banked_rw_if.sv
// ---------------------------------------------------------------------------
// array_banked_rw_if
//   Request/response bundle for the banked single-port read/write array.
//   The requester drives the master modport and the array uses the slave
//   modport.
//
//   Signals
//     RW0_addr    word address; upper log2(BANKS) bits select the bank
//     RW0_en      access request
//     RW0_wmode   1 = write, 0 = read
//     RW0_wdata   write data
//     RW0_wmask   per-lane write enable, one bit per MASK_GRAN bits of data
//     RW0_rdata   registered read data
//     RW0_rvalid  one-cycle strobe marking fresh RW0_rdata
//     RW0_ready   array accepts requests (zero-init sweep complete)
// ---------------------------------------------------------------------------
interface array_banked_rw_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 14,
    parameter int MASK_GRAN  = 8
);
    localparam int MASK_W = DATA_WIDTH / MASK_GRAN;

    logic [ADDR_WIDTH-1:0] RW0_addr;
    logic                  RW0_en;
    logic                  RW0_wmode;
    logic [DATA_WIDTH-1:0] RW0_wdata;
    logic [MASK_W-1:0]     RW0_wmask;
    logic [DATA_WIDTH-1:0] RW0_rdata;
    logic                  RW0_rvalid;
    logic                  RW0_ready;

    modport master (
        output RW0_addr,
        output RW0_en,
        output RW0_wmode,
        output RW0_wdata,
        output RW0_wmask,
        input  RW0_rdata,
        input  RW0_rvalid,
        input  RW0_ready
    );

    modport slave (
        input  RW0_addr,
        input  RW0_en,
        input  RW0_wmode,
        input  RW0_wdata,
        input  RW0_wmask,
        output RW0_rdata,
        output RW0_rvalid,
        output RW0_ready
    );
endinterface

// File: rtl/array_banked_rw.sv
// ---------------------------------------------------------------------------
// array_banked_rw
//   Parametrised single-port read/write array split into BANKS equal banks.
//   Only the addressed bank is enabled per access. Writes honour a per-lane
//   mask. Reads are registered and flagged by a one-cycle rvalid strobe.
//   After reset a hardware sweep writes zero to every word (all banks in
//   parallel, one index per cycle); requests are ignored until RW0_ready.
//
//   Ports
//     RW0_clk    clock, rising edge
//     RW0_rst_n  synchronous active-low reset
//     bus        array_banked_rw_if.slave (addr/en/wmode/wdata/wmask in,
//                rdata/rvalid/ready out)
//
//   Build option
//     ARRAY_RD_PIPE_EN  when defined, adds one output register stage on
//                       rdata/rvalid (read latency 2 instead of 1).
//
//   State table
//     state   | meaning
//     --------+---------------------------------------------------------
//     ST_INIT | zero-init sweep, index init_cnt in every bank; not ready
//     ST_RUN  | normal operation; requests accepted
// ---------------------------------------------------------------------------
module array_banked_rw #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 14,
    parameter int BANKS      = 4,
    parameter int MASK_GRAN  = 8
) (
    input  logic             RW0_clk,
    input  logic             RW0_rst_n,
    array_banked_rw_if.slave bus
);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int MASK_W     = DATA_WIDTH / MASK_GRAN;
    localparam int BANK_BITS  = $clog2(BANKS);
    localparam int SEL_W      = (BANKS > 1) ? BANK_BITS : 1;
    localparam int BANK_DEPTH = DEPTH / BANKS;
    localparam int IDX_BITS   = ADDR_WIDTH - BANK_BITS;
    localparam int IDX_W      = (IDX_BITS > 0) ? IDX_BITS : 1;

    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(BANK_DEPTH - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((BANKS < 1) || ((BANKS & (BANKS - 1)) != 0) || (BANKS > DEPTH)) begin : g_bad_banks
        $error("array_banked_rw: BANKS must be a power of two between 1 and DEPTH");
    end

    if ((MASK_GRAN < 1) || ((DATA_WIDTH % MASK_GRAN) != 0)) begin : g_bad_gran
        $error("array_banked_rw: MASK_GRAN must divide DATA_WIDTH");
    end

    // ------------------------------------------------------------------
    // Address split: bank field on top, word index within bank below
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] req_sel;
    logic [IDX_W-1:0] req_idx;

    if (BANKS == 1) begin : g_sel_single
        assign req_sel = '0;
    end else begin : g_sel_multi
        assign req_sel = bus.RW0_addr[ADDR_WIDTH-1 -: BANK_BITS];
    end

    if (IDX_BITS == 0) begin : g_idx_none
        assign req_idx = '0;
    end else begin : g_idx_some
        assign req_idx = bus.RW0_addr[IDX_BITS-1:0];
    end

    // ------------------------------------------------------------------
    // Init / run sequencer
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] init_cnt;
    logic             ready_q;

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates both sources of array writes so that a reset edge never
    // changes stored contents.
    logic init_we;
    logic accepted;
    logic rd_accepted;

    assign init_we     = (state == ST_INIT) && RW0_rst_n;
    assign accepted    = bus.RW0_en && ready_q && RW0_rst_n;
    assign rd_accepted = accepted && !bus.RW0_wmode;

    // ------------------------------------------------------------------
    // Banks: each has its own storage and its own read register. A bank's
    // read register only loads on a read addressed to that bank, so the
    // selected register keeps the last read value until the next read.
    // ------------------------------------------------------------------
    logic [BANKS-1:0][DATA_WIDTH-1:0] bank_dout;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  bank_en;
        logic                  we;
        logic [IDX_W-1:0]      widx;
        logic [DATA_WIDTH-1:0] wd;
        logic [MASK_W-1:0]     wm;

        assign bank_en = accepted && (req_sel == SEL_W'(b));
        assign we      = init_we || (bank_en && bus.RW0_wmode);
        assign widx    = init_we ? init_cnt : req_idx;
        assign wd      = init_we ? '0 : bus.RW0_wdata;
        assign wm      = init_we ? '1 : bus.RW0_wmask;

        always_ff @(posedge RW0_clk) begin
            if (we) begin
                for (int l = 0; l < MASK_W; l++) begin
                    if (wm[l]) begin
                        mem[widx][l*MASK_GRAN +: MASK_GRAN] <= wd[l*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end

        always_ff @(posedge RW0_clk) begin
            if (!RW0_rst_n) begin
                rd_q <= '0;
            end else if (bank_en && !bus.RW0_wmode) begin
                rd_q <= mem[req_idx];
            end
        end

        assign bank_dout[b] = rd_q;
    end

    // ------------------------------------------------------------------
    // First output stage: remember which bank answered the last read.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]      rd_sel_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            rd_sel_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_accepted;
            if (rd_accepted) begin
                rd_sel_q <= req_sel;
            end
        end
    end

    assign rd_data = bank_dout[rd_sel_q];

`ifdef ARRAY_RD_PIPE_EN
    // Second output stage: captures only on a first-stage strobe, so it
    // holds between reads and a write right after a read cannot disturb it.
    logic [DATA_WIDTH-1:0] rdata_p;
    logic                  rvalid_p;

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            rdata_p  <= '0;
            rvalid_p <= 1'b0;
        end else begin
            rvalid_p <= rvalid_q;
            if (rvalid_q) begin
                rdata_p <= rd_data;
            end
        end
    end

    assign bus.RW0_rdata  = rdata_p;
    assign bus.RW0_rvalid = rvalid_p;
`else
    assign bus.RW0_rdata  = rd_data;
    assign bus.RW0_rvalid = rvalid_q;
`endif

    assign bus.RW0_ready = ready_q;

endmodule

// File: tb/tb_array_banked_rw.sv
module tb_array_banked_rw;
    localparam int DW         = 64;
    localparam int AW         = 14;
    localparam int NB         = 4;
    localparam int MG         = 8;
    localparam int MW         = DW / MG;
    localparam int BANK_DEPTH = (1 << AW) / NB;
`ifdef ARRAY_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    array_banked_rw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(MG)) bus ();

    array_banked_rw #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BANKS     (NB),
        .MASK_GRAN (MG)
    ) dut (
        .RW0_clk  (clk),
        .RW0_rst_n(rst_n),
        .bus      (bus)
    );

    initial forever #5 clk = ~clk;

    // Reference model: sparse word store (absent = 0), readiness counter and
    // a queue of read results that emerge LAT cycles after acceptance.
    logic [DW-1:0] mem_m [int];
    logic          m_ready     = 1'b0;
    int            m_init_left = 0;
    logic          q_v [$];
    logic [DW-1:0] q_d [$];
    logic          exp_rvalid = 1'b0;
    logic [DW-1:0] exp_rdata  = '0;

    function automatic logic [DW-1:0] model_rd(input int a);
        return mem_m.exists(a) ? mem_m[a] : '0;
    endfunction

    function automatic void model_wr(input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic [DW-1:0] w;
        w = model_rd(a);
        for (int i = 0; i < MW; i++)
            if (m[i]) w[i*MG +: MG] = d[i*MG +: MG];
        mem_m[a] = w;
    endfunction

    // One clock: drive the request, advance the model across the edge,
    // leave the caller 1 time unit after the edge to sample outputs.
    task automatic cycle(input logic en, input logic wm, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [MW-1:0] msk);
        logic          acc;
        logic [DW-1:0] rv;
        logic          v;
        logic [DW-1:0] d;
        bus.RW0_en    = en;
        bus.RW0_wmode = wm;
        bus.RW0_addr  = a;
        bus.RW0_wdata = wd;
        bus.RW0_wmask = msk;
        acc = en && m_ready && rst_n;
        rv  = model_rd(int'(a));
        if (acc && wm) model_wr(int'(a), wd, msk);
        @(posedge clk);
        if (!rst_n) begin
            m_init_left = BANK_DEPTH;
            m_ready     = 1'b0;
            mem_m.delete();
            q_v.delete();
            q_d.delete();
            repeat (LAT - 1) begin
                q_v.push_back(1'b0);
                q_d.push_back('0);
            end
            exp_rvalid = 1'b0;
            exp_rdata  = '0;
        end else begin
            if (m_init_left > 0) begin
                m_init_left--;
                if (m_init_left == 0) m_ready = 1'b1;
            end
            q_v.push_back(acc && !wm);
            q_d.push_back(rv);
            v = q_v.pop_front();
            d = q_d.pop_front();
            exp_rvalid = v;
            if (v) exp_rdata = d;
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, AW'(i), '0, '0);
            checks++;
            if (bus.RW0_ready !== 1'b0) begin
                errors++; $display("FAIL reset_ready got %0b want 0", bus.RW0_ready);
            end
            checks++;
            if (bus.RW0_rvalid !== 1'b0) begin
                errors++; $display("FAIL reset_rvalid got %0b want 0", bus.RW0_rvalid);
            end
            checks++;
            if (bus.RW0_rdata !== '0) begin
                errors++; $display("FAIL reset_rdata got %h want 0", bus.RW0_rdata);
            end
        end
    endtask

    task automatic test_init_sweep();
        int            n;
        bit            seen;
        int            nv;
        logic [AW-1:0] addrs [$];
        n = 0;
        seen = 0;
        rst_n = 1'b1;
        // Writes to addr 2 while not ready must be dropped.
        for (int i = 0; i < BANK_DEPTH + 16 && !seen; i++) begin
            cycle(1'b1, 1'b1, AW'(2), DW'(64'h55), '1);
            n++;
            checks++;
            if (bus.RW0_rvalid !== 1'b0 || bus.RW0_rdata !== '0) begin
                errors++;
                $display("FAIL init_quiet cyc %0d rvalid %0b rdata %h want 0/0", n, bus.RW0_rvalid, bus.RW0_rdata);
            end
            if (bus.RW0_ready === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != BANK_DEPTH) begin
            errors++; $display("FAIL init_len got %0d cycles (seen %0b) want %0d", n, seen, BANK_DEPTH);
        end
        addrs = '{AW'(2), AW'(0), AW'(1), AW'(BANK_DEPTH-1), AW'(BANK_DEPTH), AW'(2*BANK_DEPTH-1),
                  AW'(2*BANK_DEPTH), AW'(3*BANK_DEPTH-1), AW'(3*BANK_DEPTH), AW'((1<<AW)-1)};
        for (int i = 0; i < 6; i++) addrs.push_back(AW'($urandom_range(0, (1 << AW) - 1)));
        nv = 0;
        for (int i = 0; i < addrs.size() + LAT; i++) begin
            if (i < addrs.size()) cycle(1'b1, 1'b0, addrs[i], '0, '0);
            else idle();
            if (bus.RW0_rvalid === 1'b1) begin
                nv++;
                checks++;
                if (bus.RW0_rdata !== '0) begin
                    errors++; $display("FAIL init_zero read %0d got %h want 0", nv, bus.RW0_rdata);
                end
            end
            checks++;
            if (bus.RW0_rvalid !== exp_rvalid) begin
                errors++; $display("FAIL init_rd_rvalid got %0b want %0b", bus.RW0_rvalid, exp_rvalid);
            end
        end
        checks++;
        if (nv != addrs.size()) begin
            errors++; $display("FAIL init_rd_count got %0d want %0d", nv, addrs.size());
        end
    endtask

    task automatic test_masked_write();
        int            nv;
        int            pos;
        logic [DW-1:0] got;
        nv = 0; pos = -1; got = '0;
        cycle(1'b1, 1'b1, AW'(5), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        cycle(1'b1, 1'b1, AW'(5), 64'h1122_3344_5566_7788, 8'h0F);
        cycle(1'b1, 1'b1, AW'(5), 64'h0, 8'h00);
        for (int i = 0; i <= LAT; i++) begin
            if (i == 0) cycle(1'b1, 1'b0, AW'(5), '0, '0);
            else idle();
            if (bus.RW0_rvalid === 1'b1) begin
                nv++; pos = i; got = bus.RW0_rdata;
            end
            checks++;
            if (bus.RW0_rvalid !== exp_rvalid || bus.RW0_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL mask_model cyc %0d got %0b/%h want %0b/%h", i, bus.RW0_rvalid, bus.RW0_rdata, exp_rvalid, exp_rdata);
            end
        end
        checks++;
        if (nv != 1 || pos != LAT - 1) begin
            errors++; $display("FAIL mask_strobe got %0d strobes at %0d want 1 at %0d", nv, pos, LAT - 1);
        end
        checks++;
        if (got !== 64'hFFFF_FFFF_5566_7788) begin
            errors++; $display("FAIL mask_data got %h want ffffffff55667788", got);
        end
    endtask

    task automatic test_bank_isolation();
        logic [AW-1:0] rd_a [4];
        logic [DW-1:0] want [4];
        logic [DW-1:0] got [$];
        rd_a = '{AW'(16'h0003), AW'(16'h3003), AW'(16'h1003), AW'(16'h2003)};
        want = '{DW'(64'hA), DW'(64'hB), DW'(0), DW'(0)};
        cycle(1'b1, 1'b1, AW'(16'h0003), DW'(64'hA), '1);
        cycle(1'b1, 1'b1, AW'(16'h3003), DW'(64'hB), '1);
        for (int i = 0; i < 4 + LAT; i++) begin
            if (i < 4) cycle(1'b1, 1'b0, rd_a[i], '0, '0);
            else idle();
            if (bus.RW0_rvalid === 1'b1) got.push_back(bus.RW0_rdata);
            checks++;
            if (bus.RW0_rvalid !== exp_rvalid || bus.RW0_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL bank_model cyc %0d got %0b/%h want %0b/%h", i, bus.RW0_rvalid, bus.RW0_rdata, exp_rvalid, exp_rdata);
            end
        end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bank_count got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++; $display("FAIL bank_data addr %h got %h want %h", rd_a[i], got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v [3];
        int            hits [$];
        logic [DW-1:0] dat [$];
        for (int k = 0; k < 3; k++) begin
            v[k] = {$urandom, $urandom};
            cycle(1'b1, 1'b1, AW'(k + 1), v[k], '1);
        end
        for (int i = 0; i < 3 + LAT + 3; i++) begin
            if (i < 3) cycle(1'b1, 1'b0, AW'(i + 1), '0, '0);
            else idle();
            if (bus.RW0_rvalid === 1'b1) begin
                hits.push_back(i); dat.push_back(bus.RW0_rdata);
            end
            checks++;
            if (bus.RW0_rvalid !== exp_rvalid || bus.RW0_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL b2b_model cyc %0d got %0b/%h want %0b/%h", i, bus.RW0_rvalid, bus.RW0_rdata, exp_rvalid, exp_rdata);
            end
        end
        checks++;
        if (hits.size() != 3) begin
            errors++; $display("FAIL b2b_count got %0d want 3", hits.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (hits[k] != LAT - 1 + k || dat[k] !== v[k]) begin
                    errors++;
                    $display("FAIL b2b_beat %0d got cyc %0d data %h want cyc %0d data %h", k, hits[k], dat[k], LAT - 1 + k, v[k]);
                end
            end
        end
        checks++;
        if (bus.RW0_rvalid !== 1'b0 || bus.RW0_rdata !== v[2]) begin
            errors++; $display("FAIL b2b_hold got %0b/%h want 0/%h", bus.RW0_rvalid, bus.RW0_rdata, v[2]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [MW-1:0] m;
            logic          en;
            logic          wm;
            int            r;
            a  = AW'($urandom_range(0, NB - 1) * BANK_DEPTH + $urandom_range(0, 5));
            d  = {$urandom, $urandom};
            r  = $urandom_range(0, 7);
            m  = (r == 0) ? '0 : (r == 1) ? '1 : MW'($urandom);
            en = ($urandom_range(0, 4) != 0);
            wm = $urandom_range(0, 1) == 1;
            cycle(en, wm, a, d, m);
            checks++;
            if (bus.RW0_rvalid !== exp_rvalid) begin
                errors++; $display("FAIL rand_rvalid cyc %0d got %0b want %0b", i, bus.RW0_rvalid, exp_rvalid);
            end
            checks++;
            if (bus.RW0_rdata !== exp_rdata) begin
                errors++; $display("FAIL rand_rdata cyc %0d got %h want %h", i, bus.RW0_rdata, exp_rdata);
            end
            checks++;
            if (bus.RW0_ready !== m_ready) begin
                errors++; $display("FAIL rand_ready cyc %0d got %0b want %0b", i, bus.RW0_ready, m_ready);
            end
        end
    endtask

    task automatic test_reset_mid_init();
        logic [AW-1:0] pool [5];
        int            n;
        bit            seen;
        int            nv;
        pool = '{AW'(0), AW'(5), AW'(BANK_DEPTH - 1), AW'(2*BANK_DEPTH + 7), AW'((1 << AW) - 1)};
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, pool[k], {$urandom, $urandom} | 64'h1, '1);
        cycle(1'b1, 1'b0, pool[4], '0, '0);
        repeat (LAT) idle();
        checks++;
        if (bus.RW0_rdata !== exp_rdata) begin
            errors++; $display("FAIL mid_pre_rdata got %h want %h", bus.RW0_rdata, exp_rdata);
        end
        for (int ph = 0; ph < 2; ph++) begin
            rst_n = 1'b0;
            cycle(1'b1, 1'b0, pool[4], '0, '0);
            checks++;
            if (bus.RW0_rdata !== '0 || bus.RW0_rvalid !== 1'b0 || bus.RW0_ready !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst%0d got rdata %h rvalid %0b ready %0b want 0/0/0", ph, bus.RW0_rdata, bus.RW0_rvalid, bus.RW0_ready);
            end
            rst_n = 1'b1;
            if (ph == 0) begin
                for (int i = 0; i < 2; i++) begin
                    cycle(1'b1, 1'b1, pool[0], '1, '1);
                    checks++;
                    if (bus.RW0_ready !== 1'b0) begin
                        errors++; $display("FAIL mid_early_ready cyc %0d got %0b want 0", i, bus.RW0_ready);
                    end
                end
            end
        end
        n = 0; seen = 0;
        for (int i = 0; i < BANK_DEPTH + 16 && !seen; i++) begin
            idle();
            n++;
            if (bus.RW0_ready === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != BANK_DEPTH) begin
            errors++; $display("FAIL mid_init_len got %0d cycles (seen %0b) want %0d", n, seen, BANK_DEPTH);
        end
        nv = 0;
        for (int i = 0; i < 5 + LAT; i++) begin
            if (i < 5) cycle(1'b1, 1'b0, pool[i], '0, '0);
            else idle();
            if (bus.RW0_rvalid === 1'b1) begin
                nv++;
                checks++;
                if (bus.RW0_rdata !== '0) begin
                    errors++; $display("FAIL mid_zero read %0d got %h want 0", nv, bus.RW0_rdata);
                end
            end
        end
        checks++;
        if (nv != 5) begin
            errors++; $display("FAIL mid_rd_count got %0d want 5", nv);
        end
    endtask

    initial begin
        bus.RW0_en    = 1'b0;
        bus.RW0_wmode = 1'b0;
        bus.RW0_addr  = '0;
        bus.RW0_wdata = '0;
        bus.RW0_wmask = '0;
        #2;
        test_reset();
        test_init_sweep();
        test_masked_write();
        test_bank_isolation();
        test_back_to_back();
        test_random();
        test_reset_mid_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
